// File: rtl/riscv_pkg.sv
// Shared RISC-V register-file constants: default data width, default register count,
// register-address type and the hardwired-zero register index.
package riscv_pkg;
  localparam int XLEN_DEFAULT     = 64;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int REG_ADDR_W       = $clog2(NUM_REGS_DEFAULT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/register_file_scoreboard.sv
// Per-register busy bits and registered population count; updates on the edge after reserve/clear.
// Reserve beats a same-cycle clear so the newest producer keeps the register busy.
module register_file_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic [NUM_REGS-1:0] clr_mask_i,
  input  logic              reserve_en_i,
  input  logic [ADDR_W-1:0] reserve_addr_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [ADDR_W:0]   busy_count_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     count_q, count_d;

  always_comb begin
    busy_d = busy_q & ~clr_mask_i;
    if (reserve_en_i && (reserve_addr_i != ADDR_W'(REG_ZERO))) begin
      busy_d[reserve_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Count is taken from next-state bits so it always matches busy_q after the edge.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/param_register_file.sv
// Multi-port integer register file with busy scoreboard; reads combinational, writes at posedge.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear busy) to matching reads.
module param_register_file
  import riscv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int NUM_REGS    = NUM_REGS_DEFAULT,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [READ_PORTS*ADDR_W-1:0]  readRegister,
  output logic [READ_PORTS*XLEN-1:0]    readData,
  output logic [READ_PORTS-1:0]         readBusy,
  input  logic [WRITE_PORTS-1:0]        regWrite,
  input  logic [WRITE_PORTS*ADDR_W-1:0] writeRegister,
  input  logic [WRITE_PORTS*XLEN-1:0]   writeData,
  input  logic                          reserveEnable,
  input  logic [ADDR_W-1:0]             reserveRegister,
  output logic [ADDR_W:0]               busyCount
);

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [XLEN-1:0]   regs_d [NUM_REGS];
  logic [ADDR_W-1:0] wr_addr [WRITE_PORTS];
  logic [XLEN-1:0]   wr_dat  [WRITE_PORTS];
  logic              wr_act  [WRITE_PORTS];
  logic [ADDR_W-1:0] rd_addr [READ_PORTS];
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy;

  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      wr_addr[p] = writeRegister[p*ADDR_W +: ADDR_W];
      wr_dat[p]  = writeData[p*XLEN +: XLEN];
      wr_act[p]  = regWrite[p] && (wr_addr[p] != ADDR_W'(REG_ZERO));
    end
  end

  // Ports are applied in ascending order so the highest-index writer wins a collision.
  always_comb begin
    regs_d   = regs_q;
    clr_mask = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wr_act[p]) begin
        regs_d[wr_addr[p]]   = wr_dat[p];
        clr_mask[wr_addr[p]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  register_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clock          (clock),
    .resetN         (resetN),
    .clr_mask_i     (clr_mask),
    .reserve_en_i   (reserveEnable),
    .reserve_addr_i (reserveRegister),
    .busy_o         (busy),
    .busy_count_o   (busyCount)
  );

  always_comb begin
    readData = '0;
    readBusy = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      rd_addr[r] = readRegister[r*ADDR_W +: ADDR_W];
      if (rd_addr[r] != ADDR_W'(REG_ZERO)) begin
        readData[r*XLEN +: XLEN] = regs_q[rd_addr[r]];
        readBusy[r]              = busy[rd_addr[r]];
      end
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_act[p] && (wr_addr[p] == rd_addr[r])) begin
          readData[r*XLEN +: XLEN] = wr_dat[p];
          readBusy[r]              = reserveEnable && (reserveRegister == rd_addr[r]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file (2 read / 2 write ports): directed table, corner sequences, random vs model.
module tb_param_register_file;
  localparam int XL = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  logic           clock = 1'b0;
  logic           resetN;
  logic [2*AW-1:0] readRegister;
  logic [2*XL-1:0] readData;
  logic [1:0]     readBusy;
  logic [1:0]     regWrite;
  logic [2*AW-1:0] writeRegister;
  logic [2*XL-1:0] writeData;
  logic           reserveEnable;
  logic [AW-1:0]  reserveRegister;
  logic [AW:0]    busyCount;

  always #5 clock = ~clock;

  param_register_file #(
    .XLEN(XL), .NUM_REGS(NR), .READ_PORTS(2), .WRITE_PORTS(2)
  ) dut (
    .clock(clock), .resetN(resetN),
    .readRegister(readRegister), .readData(readData), .readBusy(readBusy),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .reserveEnable(reserveEnable), .reserveRegister(reserveRegister),
    .busyCount(busyCount)
  );

  int errors = 0;
  int checks = 0;

  logic [XL-1:0] m_mem [NR];
  logic          m_busy [NR];

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [XL-1:0] wd0, wd1;
    logic          res;
    logic [AW-1:0] rr, ra0, ra1;
    logic [XL-1:0] exp_d0, exp_d1;
    logic          exp_b0;
    logic [AW:0]   exp_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] we,
                       input logic [AW-1:0] wa0, input logic [XL-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [XL-1:0] wd1,
                       input logic res, input logic [AW-1:0] rr,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    resetN          = rst;
    regWrite        = we;
    writeRegister   = {wa1, wa0};
    writeData       = {wd1, wd0};
    reserveEnable   = res;
    reserveRegister = rr;
    readRegister    = {ra1, ra0};
    #2;
  endtask

  // Advance one edge and apply the architectural rules to the reference model.
  task automatic tick();
    logic [AW-1:0] wa;
    @(posedge clock);
    if (!resetN) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        wa = writeRegister[p*AW +: AW];
        if (regWrite[p] && wa != 0) begin
          m_mem[wa]  = writeData[p*XL +: XL];
          m_busy[wa] = 1'b0;
        end
      end
      if (reserveEnable && reserveRegister != 0) m_busy[reserveRegister] = 1'b1;
    end
    #1;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic check_model();
    logic [AW-1:0] ra, wa;
    logic [XL-1:0] ed;
    logic          eb;
    for (int r = 0; r < 2; r++) begin
      ra = readRegister[r*AW +: AW];
      ed = (ra == 0) ? '0 : m_mem[ra];
      eb = (ra == 0) ? 1'b0 : m_busy[ra];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        wa = writeRegister[p*AW +: AW];
        if (regWrite[p] && wa != 0 && wa == ra) begin
          ed = writeData[p*XL +: XL];
          eb = reserveEnable && (reserveRegister == ra);
        end
      end
`else
      wa = '0;
`endif
      chk($sformatf("rnd_data%0d", r), readData[r*XL +: XL], ed);
      chk($sformatf("rnd_busy%0d", r), XL'(readBusy[r]), XL'(eb));
    end
    chk("rnd_count", XL'(busyCount), XL'(model_count()));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end

    // Reset with write/reserve asserted: both must be ignored.
    drive(1'b0, 2'b01, 5'd9, 64'hFFFF, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, AW'(i), AW'(i+16));
      chk("rst_data0", readData[XL-1:0], '0);
      chk("rst_data1", readData[2*XL-1:XL], '0);
      chk("rst_busy", XL'(readBusy), '0);
      chk("rst_count", XL'(busyCount), '0);
      tick();
    end

    for (int i = 0; i < NR; i++) begin
      drive(1'b1, 2'b01, AW'(i), XL'(i+1), '0, '0, 1'b0, '0, '0, '0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, AW'(i), AW'(i+16));
      chk("fill_lo", readData[XL-1:0], (i == 0) ? '0 : XL'(i+1));
      chk("fill_hi", readData[2*XL-1:XL], XL'(i+17));
      tick();
    end

    tbl[0]  = '{2'b11, 5'd5, 5'd5, 64'hAAAA, 64'h5555, 1'b0, 5'd0, 5'd6, 5'd4, 64'd7, 64'd5, 1'b0, 6'd0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd0, 64'h5555, 64'd0, 1'b0, 6'd0};
    tbl[2]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd7, 5'd7, 5'd0, 64'd8, 64'd0, 1'b0, 6'd0};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0, 64'd8, 64'd0, 1'b1, 6'd1};
    tbl[4]  = '{2'b01, 5'd7, 5'd0, 64'h1234, 64'h0, 1'b0, 5'd0, 5'd8, 5'd6, 64'd9, 64'd7, 1'b0, 6'd1};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0, 64'h1234, 64'd0, 1'b0, 6'd0};
    tbl[6]  = '{2'b01, 5'd7, 5'd0, 64'h99, 64'h0, 1'b1, 5'd7, 5'd1, 5'd0, 64'd2, 64'd0, 1'b0, 6'd0};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0, 64'h99, 64'd0, 1'b1, 6'd1};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd7, 5'd7, 5'd0, 64'h99, 64'd0, 1'b1, 6'd1};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0, 64'h99, 64'd0, 1'b1, 6'd1};
    tbl[10] = '{2'b01, 5'd0, 5'd0, 64'hFFFF, 64'h0, 1'b0, 5'd0, 5'd2, 5'd0, 64'd3, 64'd0, 1'b0, 6'd1};
    tbl[11] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 6'd1};

    for (int v = 0; v < 12; v++) begin
      drive(1'b1, tbl[v].we, tbl[v].wa0, tbl[v].wd0, tbl[v].wa1, tbl[v].wd1,
            tbl[v].res, tbl[v].rr, tbl[v].ra0, tbl[v].ra1);
      chk($sformatf("tbl%0d_d0", v), readData[XL-1:0], tbl[v].exp_d0);
      chk($sformatf("tbl%0d_d1", v), readData[2*XL-1:XL], tbl[v].exp_d1);
      chk($sformatf("tbl%0d_b0", v), XL'(readBusy[0]), XL'(tbl[v].exp_b0));
      chk($sformatf("tbl%0d_cnt", v), XL'(busyCount), XL'(tbl[v].exp_cnt));
      tick();
    end

    // Same-cycle write/read of register 3 (old value 4), register 7 still busy.
    drive(1'b1, 2'b01, 5'd3, 64'hDEADBEEF, 5'd0, '0, 1'b0, '0, 5'd3, 5'd7);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same_cycle", readData[XL-1:0], 64'hDEADBEEF);
`else
    chk("byp_same_cycle", readData[XL-1:0], 64'd4);
`endif
    chk("byp_busy7", XL'(readBusy[1]), 64'd1);
    tick();
    drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, 5'd3, 5'd0);
    chk("byp_next_cycle", readData[XL-1:0], 64'hDEADBEEF);
    tick();

    // Write and reserve register 2 together.
    drive(1'b1, 2'b10, 5'd0, '0, 5'd2, 64'h77, 1'b1, 5'd2, 5'd2, 5'd0);
`ifdef REGFILE_BYPASS_EN
    chk("rsv_wr_data", readData[XL-1:0], 64'h77);
    chk("rsv_wr_busy", XL'(readBusy[0]), 64'd1);
`else
    chk("rsv_wr_data", readData[XL-1:0], 64'd3);
    chk("rsv_wr_busy", XL'(readBusy[0]), 64'd0);
`endif
    tick();
    drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, 5'd2, 5'd0);
    chk("rsv_wr_after_data", readData[XL-1:0], 64'h77);
    chk("rsv_wr_after_busy", XL'(readBusy[0]), 64'd1);
    chk("rsv_wr_after_cnt", XL'(busyCount), 64'd2);
    tick();

    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b1, AW'(i), '0, '0);
      tick();
    end
    drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, 5'd1, 5'd4);
    chk("rsv4_cnt", XL'(busyCount), 64'd5);
    chk("rsv4_busy", XL'(readBusy), 64'd3);
    tick();
    drive(1'b0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 1'b1, 5'd3, '0, '0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0, AW'(i), AW'(i+16));
      chk("mid_rst_data0", readData[XL-1:0], '0);
      chk("mid_rst_data1", readData[2*XL-1:XL], '0);
      chk("mid_rst_busy", XL'(readBusy), '0);
      chk("mid_rst_cnt", XL'(busyCount), '0);
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a0, a1;
      a0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? a0 : AW'($urandom_range(0, 7));
      drive(($urandom_range(0, 49) != 0), 2'($urandom),
            a0, {$urandom, $urandom}, a1, {$urandom, $urandom},
            ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), AW'($urandom));
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-port integer register file for the RISC-V core, successor to the fixed 32×64, 2-read/1-write file. Adds configurable width, depth, read/write port counts, a hardwired-zero register 0, synchronous clear and a per-register busy scoreboard so the pipeline's issue stage can stall on outstanding writes. Sits between decode/issue (reads, reservations) and writeback (writes).

## Interface
Parameters:
- XLEN, 64, data width in bits (32 or 64)
- NUM_REGS, 32, register count (power of two, 2..64)
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 1, number of write ports (1..2)
- ADDR_W, $clog2(NUM_REGS), register address width (derived)

Ports (port arrays packed, port 0 in LSBs):
- clock  in  1  rising-edge clock
- resetN  in  1  synchronous, active-low reset
- readRegister  in  READ_PORTS*ADDR_W  read addresses
- readData  out  READ_PORTS*XLEN  read data
- readBusy  out  READ_PORTS  addressed register has an outstanding write
- regWrite  in  WRITE_PORTS  per-port write enable
- writeRegister  in  WRITE_PORTS*ADDR_W  write addresses
- writeData  in  WRITE_PORTS*XLEN  write data
- reserveEnable  in  1  mark reserveRegister busy
- reserveRegister  in  ADDR_W  register to reserve
- busyCount  out  ADDR_W+1  number of busy registers

## Operation
- One clock, `clock`; reset is synchronous and active-low, `resetN`.
- Reset (resetN=0 at posedge): all registers 0, all busy bits 0, busyCount 0; regWrite/reserveEnable ignored that cycle. Reset mid-sequence discards all pending reservations.
- Reads combinational from addresses; register 0 always reads 0, never busy.
- Writes commit at posedge when regWrite[p]=1 and writeRegister[p]≠0; writes to 0 dropped.
- Two write ports, same address, same cycle: higher port index wins.
- Scoreboard: reserveEnable=1, reserveRegister≠0 sets busy at posedge. Any committed write clears that register's busy bit.
- Reserve and write to same register same cycle: busy stays 1 (new producer supersedes).
- Reserve of an already-busy register: stays 1, no count change.
- busyCount = population count of busy bits, registered, consistent with busy bits at all times (updated same edge).
- Out-of-range addresses cannot occur (NUM_REGS power of two).

## Timing
- Read latency 0 (combinational) from readRegister and register state.
- Write-to-read: value visible from the cycle after the committing edge (0-cycle with bypass, see Configuration).
- Reserve-to-busy: readBusy asserts the cycle after the reserving edge.
- Write-to-unbusy: readBusy deasserts the cycle after the committing write edge.
- All outputs reset: readData 0 for every address, readBusy 0, busyCount 0.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an active write (≠0) in the same cycle returns writeData (highest matching port) and readBusy=0 for that port, unless reserveEnable also targets it that cycle (readBusy then 1, data still forwarded).
- Undefined: no forwarding; readData/readBusy reflect only registered state.

## Structure
- Shared package riscv_pkg: XLEN default, reg-address typedef, register-0 constant.
- One sub-module: register_file_scoreboard (busy bits, reserve/clear priority, busyCount). Storage array, write priority, bypass mux in the top.

## Test plan
- Reset, then read all 32 addresses on 2 ports -> all readData 0, readBusy 0, busyCount 0.
- Write i+1 to register i for i=0..31, then read back -> register 0 reads 0, register i reads i+1.
- Ports 0 and 1 write 0xAAAA and 0x5555 to register 5 same cycle -> register 5 reads 0x5555.
- Reserve register 7 -> readBusy=1, busyCount=1 next cycle; write 0x1234 to 7 -> readBusy=0, busyCount=0, readData 0x1234; reserve+write 7 same cycle -> busy stays 1.
- With REGFILE_BYPASS_EN, write 0xDEADBEEF to register 3 while reading 3 -> same-cycle readData 0xDEADBEEF; without macro -> old value, new value next cycle.
- Reserve registers 1..4, assert resetN=0 one cycle -> busyCount 0, all registers 0.
